// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmitter: FSM state encoding and sizing helpers.
package uart_tx_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } tx_state_t;

   // Never returns less than 1, so a counter or index always has at least one bit.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return (r < 1) ? 1 : r;
   endfunction

   function automatic int cycles_per_bit(input int clk_hz, input int bit_rate);
      return clk_hz / bit_rate;
   endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte handshake into the UART transmitter: the producer drives valid/data.
// The transmitter answers with ready, and a byte moves on valid && ready.
interface uart_tx_if #(
   parameter int PAYLOAD_BITS = 8
) ();
   logic                    uart_tx_valid;
   logic [PAYLOAD_BITS-1:0] uart_tx_data;
   logic                    uart_tx_ready;

   modport master (output uart_tx_valid, output uart_tx_data, input  uart_tx_ready);
   modport slave  (input  uart_tx_valid, input  uart_tx_data, output uart_tx_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO with show-ahead read data, so the head entry is visible before it is popped.
// Pushes while full and pops while empty are ignored, and full/empty come straight from the registered pointers.
module uart_tx_fifo
   import uart_tx_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_push_dat,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_pop_dat,
   output logic             o_full,
   output logic             o_empty
);
   localparam int AW = clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic             w_push_ok;
   logic             w_pop_ok;

   assign w_push_ok = i_push && !o_full;
   assign w_pop_ok  = i_pop && !o_empty;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= i_push_dat;
   end

   assign o_pop_dat = r_mem[r_rd_ptr[AW-1:0]];
   // The extra pointer MSB tells a full FIFO apart from an empty one when the indices are equal.
   assign o_empty   = (r_wr_ptr == r_rd_ptr);
   assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter fed through a small FIFO; txd goes low on the edge after the byte is accepted.
// Ready drops only when the FIFO is full, and the next frame follows a stop bit directly when a byte is waiting.
module uart_tx
   import uart_tx_pkg::*;
#(
   parameter int BIT_RATE     = 9600,
   parameter int CLK_HZ       = 50000000,
   parameter int PAYLOAD_BITS = 8,
   parameter int STOP_BITS    = 1,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic     clk,
   input  logic     resetn,
   input  logic     uart_tx_en,
   uart_tx_if.slave tx_if,
   output logic     uart_tx_busy,
   output logic     uart_txd
);
   localparam int CYCLES_PER_BIT = cycles_per_bit(CLK_HZ, BIT_RATE);
   localparam int CNT_W          = clog2(CYCLES_PER_BIT);
   localparam int IDX_W          = clog2(PAYLOAD_BITS);

   tx_state_t               r_state;
   logic [CNT_W-1:0]        r_cnt;
   logic [IDX_W-1:0]        r_idx;
   logic [PAYLOAD_BITS-1:0] r_shift;
   logic                    r_txd;

   logic [PAYLOAD_BITS-1:0] w_fifo_dat;
   logic [PAYLOAD_BITS-1:0] w_shift_nxt;
   logic                    w_full;
   logic                    w_empty;
   logic                    w_bit_done;
   logic                    w_can_start;
   logic                    w_pop;

   assign w_bit_done  = (r_cnt == CNT_W'(CYCLES_PER_BIT - 1));
   assign w_can_start = uart_tx_en && !w_empty;
   assign w_shift_nxt = r_shift >> 1;
   assign w_pop       = w_can_start &&
                        ((r_state == S_IDLE) ||
                         ((r_state == S_STOP) && w_bit_done && (r_idx == IDX_W'(STOP_BITS - 1))));

   uart_tx_fifo #(
      .WIDTH (PAYLOAD_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk        (clk),
      .resetn     (resetn),
      .i_push     (tx_if.uart_tx_valid),
      .i_push_dat (tx_if.uart_tx_data),
      .i_pop      (w_pop),
      .o_pop_dat  (w_fifo_dat),
      .o_full     (w_full),
      .o_empty    (w_empty)
   );

   // r_txd is loaded with the level of the state being entered, so the line changes on the same edge as the state.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_idx   <= '0;
         r_shift <= '0;
         r_txd   <= 1'b1;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_txd <= 1'b1;
               if (w_pop) begin
                  r_shift <= w_fifo_dat;
                  r_cnt   <= '0;
                  r_txd   <= 1'b0;
                  r_state <= S_START;
               end
            end
            S_START: begin
               if (w_bit_done) begin
                  r_cnt   <= '0;
                  r_idx   <= '0;
                  r_txd   <= r_shift[0];
                  r_state <= S_DATA;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_DATA: begin
               if (w_bit_done) begin
                  r_cnt <= '0;
                  if (r_idx == IDX_W'(PAYLOAD_BITS - 1)) begin
                     r_idx   <= '0;
                     r_txd   <= 1'b1;
                     r_state <= S_STOP;
                  end else begin
                     r_idx   <= r_idx + 1'b1;
                     r_shift <= w_shift_nxt;
                     r_txd   <= w_shift_nxt[0];
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_STOP: begin
               if (w_bit_done) begin
                  r_cnt <= '0;
                  if (r_idx == IDX_W'(STOP_BITS - 1)) begin
                     r_idx <= '0;
                     if (w_pop) begin
                        r_shift <= w_fifo_dat;
                        r_txd   <= 1'b0;
                        r_state <= S_START;
                     end else begin
                        r_txd   <= 1'b1;
                        r_state <= S_IDLE;
                     end
                  end else begin
                     r_idx <= r_idx + 1'b1;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: begin
               r_txd   <= 1'b1;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign uart_txd            = r_txd;
   assign uart_tx_busy        = (r_state != S_IDLE) || !w_empty;
   assign tx_if.uart_tx_ready = !w_full;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx at a reduced bit period (16 clocks per bit).
// A frame-level line model is compared against the outputs on every cycle, alongside hand-computed literal checks.
module tb_uart_tx;
   localparam int CPB   = 16;
   localparam int PB    = 8;
   localparam int SB    = 1;
   localparam int DEPTH = 4;
   localparam int FRAME = (1 + PB + SB) * CPB;

   logic clk;
   logic resetn;
   logic uart_tx_en;
   logic uart_tx_busy;
   logic uart_txd;

   uart_tx_if #(.PAYLOAD_BITS(PB)) u_if ();

   uart_tx #(
      .BIT_RATE     (10),
      .CLK_HZ       (160),
      .PAYLOAD_BITS (PB),
      .STOP_BITS    (SB),
      .FIFO_DEPTH   (DEPTH)
   ) dut (
      .clk          (clk),
      .resetn       (resetn),
      .uart_tx_en   (uart_tx_en),
      .tx_if        (u_if),
      .uart_tx_busy (uart_tx_busy),
      .uart_txd     (uart_txd)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check_v(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Line model: FIFO contents as a queue, plus the position (in clocks) within the current frame.
   logic [PB-1:0] mq[$];
   logic [PB-1:0] mcur = '0;
   int            mcnt = -1;
   bit            m_push;
   bit            m_start;
   logic [PB-1:0] m_pd;

   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         mq.delete();
         mcnt = -1;
      end else begin
         m_push  = u_if.uart_tx_valid && (mq.size() < DEPTH);
         m_pd    = u_if.uart_tx_data;
         m_start = uart_tx_en && (mq.size() > 0);
         if (mcnt >= 0) begin
            mcnt++;
            if (mcnt == FRAME) mcnt = -1;
         end
         if (mcnt < 0 && m_start) begin
            mcur = mq.pop_front();
            mcnt = 0;
         end
         if (m_push) mq.push_back(m_pd);
      end
   end

   function automatic int exp_txd();
      int idx;
      if (mcnt < 0) return 1;
      idx = mcnt / CPB;
      if (idx == 0) return 0;
      if (idx <= PB) return int'(mcur[idx-1]);
      return 1;
   endfunction

   always @(negedge clk) begin
      check_v("model_txd",   int'(uart_txd), exp_txd());
      check_v("model_busy",  int'(uart_tx_busy), int'((mcnt >= 0) || (mq.size() > 0)));
      check_v("model_ready", int'(u_if.uart_tx_ready), int'(mq.size() < DEPTH));
   end

   task automatic push(input logic [7:0] b);
      bit acc;
      acc = 1'b0;
      u_if.uart_tx_valid = 1'b1;
      u_if.uart_tx_data  = b;
      for (int k = 0; k < 2000 && !acc; k++) begin
         acc = u_if.uart_tx_ready;
         @(posedge clk);
         #2;
      end
      u_if.uart_tx_valid = 1'b0;
      check_v("push_accepted", int'(acc), 1);
   endtask

   task automatic wait_busy_low(input time t0, output int cyc);
      for (int k = 0; k < 3000 && uart_tx_busy; k++) begin
         @(posedge clk);
         #2;
      end
      check_v("busy_fall_within_bound", int'(uart_tx_busy), 0);
      cyc = int'(($time - t0) / 10);
   endtask

   int   pat [10] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
   time  t_acc;
   int   cyc;

   initial begin
      resetn             = 1'b0;
      uart_tx_en         = 1'b1;
      u_if.uart_tx_valid = 1'b0;
      u_if.uart_tx_data  = '0;
      repeat (3) @(posedge clk);
      #2;
      check_v("reset_txd",   int'(uart_txd), 1);
      check_v("reset_ready", int'(u_if.uart_tx_ready), 1);
      check_v("reset_busy",  int'(uart_tx_busy), 0);
      resetn = 1'b1;
      repeat (2) @(posedge clk);
      #2;

      // 0x55, sampled at mid-bit
      push(8'h55);
      t_acc = $time;
      check_v("t1_line_high_at_accept", int'(uart_txd), 1);
      @(posedge clk);
      #2;
      check_v("t1_start_one_clk_after_accept", int'(uart_txd), 0);
      for (int k = 0; k < 10; k++) begin
         repeat ((k == 0) ? CPB / 2 : CPB) @(posedge clk);
         #2;
         check_v($sformatf("t1_midbit_%0d", k), int'(uart_txd), pat[k]);
      end
      wait_busy_low(t_acc, cyc);
      check_v("t1_busy_cycles", cyc, 161);

      // five bytes back to back
      repeat (3) @(posedge clk);
      #2;
      push(8'h13);
      t_acc = $time;
      push(8'h01);
      push(8'h01);
      push(8'hfd);
      push(8'hAA);
      check_v("t2_ready_low_when_full", int'(u_if.uart_tx_ready), 0);
      check_v("t2_busy", int'(uart_tx_busy), 1);
      wait_busy_low(t_acc, cyc);
      check_v("t2_busy_cycles", cyc, 801);

      // enable held low
      uart_tx_en = 1'b0;
      push(8'h3C);
      repeat (20) @(posedge clk);
      #2;
      check_v("t3_line_idle_disabled", int'(uart_txd), 1);
      check_v("t3_busy_disabled", int'(uart_tx_busy), 1);
      uart_tx_en = 1'b1;
      @(posedge clk);
      #2;
      check_v("t3_start_after_enable", int'(uart_txd), 0);
      t_acc = $time;
      wait_busy_low(t_acc, cyc);
      check_v("t3_busy_cycles", cyc, 160);

      // enable dropped during data bit 3
      push(8'hA5);
      push(8'h0F);
      repeat (4 * CPB + CPB / 2) @(posedge clk);
      #2;
      uart_tx_en = 1'b0;
      repeat (200) @(posedge clk);
      #2;
      check_v("t4_second_frame_held", int'(uart_txd), 1);
      check_v("t4_busy_held", int'(uart_tx_busy), 1);
      check_v("t4_ready", int'(u_if.uart_tx_ready), 1);
      uart_tx_en = 1'b1;
      @(posedge clk);
      #2;
      check_v("t4_resume_start", int'(uart_txd), 0);
      t_acc = $time;
      wait_busy_low(t_acc, cyc);
      check_v("t4_busy_cycles", cyc, 160);

      // reset during data bit 4
      push(8'hC3);
      push(8'h81);
      repeat (5 * CPB + CPB / 2) @(posedge clk);
      #2;
      check_v("t5_bit4_of_c3", int'(uart_txd), 0);
      #2;
      resetn = 1'b0;
      #1;
      check_v("t5_txd_async_high", int'(uart_txd), 1);
      check_v("t5_busy_async_low", int'(uart_tx_busy), 0);
      repeat (2) @(posedge clk);
      #2;
      resetn = 1'b1;
      check_v("t5_ready_after_release", int'(u_if.uart_tx_ready), 1);
      check_v("t5_busy_after_release", int'(uart_tx_busy), 0);
      repeat (2 * FRAME) @(posedge clk);
      #2;
      check_v("t5_no_stale_txd", int'(uart_txd), 1);
      check_v("t5_no_stale_busy", int'(uart_tx_busy), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
